adr_ldr_mov1: RTL and testbench

ADR_LDR_MOV1 -- requirements
Module: adr_ldr_mov1

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/adr_ldr_mov1_imm_zext.sv | 28 ++
 rtl/adr_ldr_mov1.sv | 148 ++++++++++++++
 tb/tb_adr_ldr_mov1.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions. Holds the 4-bit opcode map for all
//                sixteen instructions, the default datapath widths, the
//                operation class used by the ADR/LDR/MOV1 slice, and a small
//                decode helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPCODE_W  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int IMM_W_DEF  = 16;

    // Full instruction map. Only MOV1, ADR and LDR are handled by
    // adr_ldr_mov1; the rest are listed so every ALU slice shares one map.
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_MOV1 = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_MOV2 = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 4'b1001;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 4'b1010;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1011;
    localparam logic [OPCODE_W-1:0] OP_ADR  = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_LDR  = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_STR  = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b1111;

    // How this slice treats an opcode.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,   // not ours: zero result, no hit
        CLS_IMM  = 2'd1,   // MOV1 / ADR: zero-extended immediate
        CLS_LDR  = 2'd2    // LDR: zero result, address goes to memory
    } op_class_e;

    function automatic op_class_e decode_class(input logic [OPCODE_W-1:0] op);
        op_class_e cls;
        cls = CLS_NONE;
        case (op)
            OP_MOV1, OP_ADR: cls = CLS_IMM;
            OP_LDR:          cls = CLS_LDR;
            default:         cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/adr_ldr_mov1_imm_zext.sv
`default_nettype none
// ============================================================================
//  Module      : imm_zext
//  Description : Combinational zero-extension of an IMM_W-bit immediate to
//                DATA_W bits. Shared by MOV1 and ADR, whose results are
//                bit-identical.
//  Ports       : imm_i [IMM_W-1:0]  immediate / address field
//                ext_o [DATA_W-1:0] zero-extended value
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_zext #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] ext_o
);

    // A zero-width replication is illegal, so the equal-width case is split
    // out rather than padding with {0{1'b0}}.
    if (DATA_W > IMM_W) begin : g_pad
        assign ext_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
    end else begin : g_same
        assign ext_o = imm_i;
    end

endmodule : imm_zext
`default_nettype wire

// File: rtl/adr_ldr_mov1.sv
`default_nettype none
// ============================================================================
//  Module      : adr_ldr_mov1
//  Description : ALU slice for MOV R1,n / ADR / LDR. One-cycle registered
//                result, no backpressure. MOV1 and ADR return the immediate
//                zero-extended; LDR returns zero (the access itself happens
//                elsewhere); every other opcode returns zero with op_hit low.
//                When in_valid is low, out and op_hit hold and out_valid
//                drops.
//  Build option: define ADR_LDR_MOV1_MEM_REQ_EN to add mem_rd_req/mem_addr,
//                which register an LDR read request with source_1 as address.
//  Ports       : clk, rst (async, active high)
//                in_valid, opcode[3:0], immediate_value[IMM_W-1:0],
//                source_1[DATA_W-1:0]               -> inputs
//                out_valid, out[DATA_W-1:0], op_hit -> registered outputs
//                mem_rd_req, mem_addr[DATA_W-1:0]   -> optional outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module adr_ldr_mov1
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMM_W  = IMM_W_DEF     // must not exceed DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [IMM_W-1:0]    immediate_value,
    input  logic [DATA_W-1:0]   source_1,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out,
    output logic                op_hit
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
    ,
    output logic                mem_rd_req,
    output logic [DATA_W-1:0]   mem_addr
`endif
);

    // ------------------------------------------------------------------
    // Result selection (combinational)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] imm_ext_w;
    op_class_e         cls_w;
    logic [DATA_W-1:0] result_w;
    logic              hit_w;

    imm_zext #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_imm_zext (
        .imm_i (immediate_value),
        .ext_o (imm_ext_w)
    );

    assign cls_w = decode_class(opcode);

    always_comb begin
        result_w = '0;
        hit_w    = 1'b0;
        case (cls_w)
            CLS_IMM: begin
                result_w = imm_ext_w;
                hit_w    = 1'b1;
            end
            CLS_LDR: begin
                result_w = '0;
                hit_w    = 1'b1;
            end
            default: begin
                result_w = '0;
                hit_w    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_d,       out_q;
    logic              op_hit_d,    op_hit_q;
    logic              out_valid_d, out_valid_q;

    // Idle cycles keep the last result visible; only out_valid reports them.
    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        op_hit_d    = op_hit_q;
        if (in_valid) begin
            out_d    = result_w;
            op_hit_d = hit_w;
        end
    end

`ifdef ADR_LDR_MOV1_MEM_REQ_EN
    logic              mem_rd_req_d, mem_rd_req_q;
    logic [DATA_W-1:0] mem_addr_d,   mem_addr_q;

    // The address only moves on an accepted LDR so it stays stable between
    // requests.
    always_comb begin
        mem_rd_req_d = in_valid && (cls_w == CLS_LDR);
        mem_addr_d   = mem_addr_q;
        if (mem_rd_req_d) begin
            mem_addr_d = source_1;
        end
    end
`else
    // source_1 is only an address for the memory request; without that
    // feature it is intentionally left unconsumed.
    logic unused_source_1;
    assign unused_source_1 = ^source_1;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            op_hit_q     <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
`endif
        end else begin
            out_q        <= out_d;
            op_hit_q     <= op_hit_d;
            out_valid_q  <= out_valid_d;
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
            mem_rd_req_q <= mem_rd_req_d;
            mem_addr_q   <= mem_addr_d;
`endif
        end
    end

    assign out       = out_q;
    assign op_hit    = op_hit_q;
    assign out_valid = out_valid_q;
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
    assign mem_rd_req = mem_rd_req_q;
    assign mem_addr   = mem_addr_q;
`endif

endmodule : adr_ldr_mov1
`default_nettype wire

// File: tb/tb_adr_ldr_mov1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adr_ldr_mov1
//  Description : Self-checking bench for adr_ldr_mov1 (default widths).
//                Expected results are queued when a transaction is driven and
//                popped when out_valid reports a result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adr_ldr_mov1;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int IW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [3:0]    opcode;
    logic [IW-1:0] immediate_value;
    logic [DW-1:0] source_1;
    logic          out_valid;
    logic [DW-1:0] out;
    logic          op_hit;
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
    logic          mem_rd_req;
    logic [DW-1:0] mem_addr;
`endif

    adr_ldr_mov1 #(.DATA_W(DW), .IMM_W(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .opcode          (opcode),
        .immediate_value (immediate_value),
        .source_1        (source_1),
        .out_valid       (out_valid),
        .out             (out),
        .op_hit          (op_hit)
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
        ,
        .mem_rd_req      (mem_rd_req),
        .mem_addr        (mem_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          hit;
        logic          rd;
        logic [DW-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [DW-1:0] last_out = '0;
    logic          last_hit = 1'b0;

    // Independent reference: what the slice should return for one opcode.
    function automatic exp_t model(input logic [3:0] op, input logic [IW-1:0] imm,
                                   input logic [DW-1:0] src);
        exp_t e;
        e.res  = '0;
        e.hit  = 1'b0;
        e.rd   = 1'b0;
        e.addr = '0;
        if (op == 4'b0110 || op == 4'b1100) begin
            e.res = {16'h0000, imm};
            e.hit = 1'b1;
        end else if (op == 4'b1101) begin
            e.hit  = 1'b1;
            e.rd   = 1'b1;
            e.addr = src;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [IW-1:0] imm, input logic [DW-1:0] src);
        in_valid        = v;
        opcode          = op;
        immediate_value = imm;
        source_1        = src;
        if (v) sb.push_back(model(op, imm, src));
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 4'b0000, '0, '0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out !== '0) begin n_errors++; $display("FAIL reset_out actual=%h required=0", out); end
        n_checks++; if (op_hit !== 1'b0) begin n_errors++; $display("FAIL reset_hit actual=%b required=0", op_hit); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
        // Clock edges with valid input must not escape reset.
        in_valid = 1'b1; opcode = OP_MOV1; immediate_value = 16'hABCD;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || out !== '0) begin
            n_errors++; $display("FAIL reset_hold actual=%b/%h required=0/0", out_valid, out);
        end
        // First transaction after release is taken at the first edge.
        @(negedge clk);
        drive(1'b1, OP_MOV1, 16'hABCD, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL first_after_reset valid actual=%b required=1", out_valid);
        end else begin
            exp_t e = sb.pop_front();
            n_checks++; if (out !== e.res || op_hit !== e.hit) begin
                n_errors++; $display("FAIL first_after_reset actual=%h/%b required=%h/%b", out, op_hit, e.res, e.hit);
            end
            last_out = e.res; last_hit = e.hit;
        end
        drive(1'b0, OP_NOP, '0, '0);
        @(posedge clk); #1;
    endtask

    // MOV1 and ADR share the same three-immediate sequence.
    task automatic test_imm_op(input logic [3:0] op);
        logic [IW-1:0] imms [3];
        logic [DW-1:0] want [3];
        imms = '{16'h0000, 16'hABCD, 16'hDCAB};
        want = '{32'h00000000, 32'h0000ABCD, 32'h0000DCAB};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, op, imms[i], $urandom);
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin
                n_errors++; $display("FAIL imm_op%b[%0d] valid actual=%b required=1", op, i, out_valid);
            end else begin
                exp_t e = sb.pop_front();
                n_checks++; if (out !== want[i] || out !== e.res) begin
                    n_errors++; $display("FAIL imm_op%b[%0d] out actual=%h required=%h", op, i, out, want[i]);
                end
                n_checks++; if (op_hit !== 1'b1) begin
                    n_errors++; $display("FAIL imm_op%b[%0d] hit actual=%b required=1", op, i, op_hit);
                end
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
                n_checks++; if (mem_rd_req !== 1'b0) begin
                    n_errors++; $display("FAIL imm_op%b[%0d] mem_rd_req actual=%b required=0", op, i, mem_rd_req);
                end
`endif
                last_out = e.res; last_hit = e.hit;
            end
        end
        drive(1'b0, OP_NOP, '0, '0);
    endtask

    task automatic test_ldr();
        drive(1'b1, OP_LDR, 16'h5A5A, 32'hABCDABCD);
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL ldr valid actual=%b required=1", out_valid);
        end else begin
            exp_t e = sb.pop_front();
            n_checks++; if (out !== 32'h0 || op_hit !== 1'b1) begin
                n_errors++; $display("FAIL ldr out/hit actual=%h/%b required=0/1", out, op_hit);
            end
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
            n_checks++; if (mem_rd_req !== 1'b1 || mem_addr !== 32'hABCDABCD) begin
                n_errors++; $display("FAIL ldr mem actual=%b/%h required=1/abcdabcd", mem_rd_req, mem_addr);
            end
`endif
            last_out = e.res; last_hit = e.hit;
        end
        drive(1'b0, OP_NOP, '0, '0);
        @(posedge clk); #1;
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
        n_checks++; if (mem_rd_req !== 1'b0) begin
            n_errors++; $display("FAIL ldr idle mem_rd_req actual=%b required=0", mem_rd_req);
        end
`endif
    endtask

    task automatic test_unhandled();
        drive(1'b1, 4'b0000, 16'hFFFF, 32'h12345678);
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL unhandled valid actual=%b required=1", out_valid);
        end else begin
            exp_t e = sb.pop_front();
            n_checks++; if (out !== 32'h0 || op_hit !== 1'b0 || out !== e.res) begin
                n_errors++; $display("FAIL unhandled out/hit actual=%h/%b required=0/0", out, op_hit);
            end
            last_out = e.res; last_hit = e.hit;
        end
        drive(1'b0, OP_NOP, '0, '0);
    endtask

    task automatic test_hold();
        drive(1'b1, OP_MOV1, 16'h1234, '0);
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out !== 32'h00001234) begin
            n_errors++; $display("FAIL hold_load actual=%b/%h required=1/00001234", out_valid, out);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        drive(1'b0, OP_ADR, 16'hFFFF, '1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || out !== 32'h00001234 || op_hit !== 1'b1) begin
                n_errors++; $display("FAIL hold_idle[%0d] actual=%b/%h/%b required=0/00001234/1",
                                     i, out_valid, out, op_hit);
            end
        end
        last_out = 32'h00001234; last_hit = 1'b1;
    endtask

    // Random mix with idle gaps; all sixteen opcodes appear.
    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic v;
            v = (i < 16) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(v, (i < 16) ? 4'(i) : 4'($urandom_range(0, 15)), 16'($urandom), $urandom);
            @(posedge clk); #1;
            n_checks++; if (out_valid !== v) begin
                n_errors++; $display("FAIL b2b[%0d] valid actual=%b required=%b", i, out_valid, v);
            end else if (v) begin
                exp_t e = sb.pop_front();
                n_checks++; if (out !== e.res || op_hit !== e.hit) begin
                    n_errors++; $display("FAIL b2b[%0d] op=%h actual=%h/%b required=%h/%b",
                                         i, opcode, out, op_hit, e.res, e.hit);
                end
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
                n_checks++; if (mem_rd_req !== e.rd || (e.rd && mem_addr !== e.addr)) begin
                    n_errors++; $display("FAIL b2b[%0d] mem actual=%b/%h required=%b/%h",
                                         i, mem_rd_req, mem_addr, e.rd, e.addr);
                end
`endif
                last_out = e.res; last_hit = e.hit;
            end else begin
                n_checks++; if (out !== last_out || op_hit !== last_hit) begin
                    n_errors++; $display("FAIL b2b[%0d] idle_hold actual=%h/%b required=%h/%b",
                                         i, out, op_hit, last_out, last_hit);
                end
            end
        end
        drive(1'b0, OP_NOP, '0, '0);
        sb.delete();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_MOV1, 16'hFFFF, 32'hFFFFFFFF);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out !== '0 || op_hit !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_mid_async actual=%h/%b/%b required=0/0/0", out, op_hit, out_valid);
        end
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || out !== '0 || op_hit !== 1'b0) begin
                n_errors++; $display("FAIL reset_mid_release[%0d] actual=%b/%h/%b required=0/0/0",
                                     i, out_valid, out, op_hit);
            end
`ifdef ADR_LDR_MOV1_MEM_REQ_EN
            n_checks++; if (mem_rd_req !== 1'b0 || mem_addr !== '0) begin
                n_errors++; $display("FAIL reset_mid_mem[%0d] actual=%b/%h required=0/0", i, mem_rd_req, mem_addr);
            end
`endif
        end
        last_out = '0; last_hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_imm_op(4'b0110);   // MOV1
        test_imm_op(4'b1100);   // ADR
        test_ldr();
        test_unhandled();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_adr_ldr_mov1
`default_nettype wire
